// File: rtl/nes_pkg.sv
// Shared definitions for the NES memory arbiter: host opcodes, run states
// and default bus widths.
package nes_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int STEP_W_DEF = 8;

    localparam logic [7:0] OP_HALT  = 8'h00;
    localparam logic [7:0] OP_START = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_STEP  = 8'h03;

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } run_state_t;

endpackage

// File: rtl/nes_host_cmd_decode.sv
// Host slave decode: turns chipselect/read/write strobes into registered
// memory-steal requests and single-cycle run-state command pulses.
module nes_host_cmd_decode
    import nes_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [15:0]       writedata,
    input  logic [ADDR_W-1:0] address,
    output logic              hreq,
    output logic              hwe,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hdata,
    output logic              host_acc,
    output logic              cmd_halt,
    output logic              cmd_start,
    output logic              cmd_step,
    output logic [STEP_W-1:0] step_val
);

    logic       cmd_acc;
    logic       rd_acc;
    logic [7:0] opcode;

    assign opcode = writedata[15:8];

    // Command and read acceptance; a write strobe masks a simultaneous read.
    always_comb begin
        cmd_acc   = chipselect & write;
        rd_acc    = chipselect & read & ~write;
        cmd_halt  = cmd_acc & (opcode == OP_HALT);
        cmd_start = cmd_acc & (opcode == OP_START);
        cmd_step  = cmd_acc & (opcode == OP_STEP);
        host_acc  = (cmd_acc & (opcode == OP_WRITE)) | rd_acc;
        step_val  = writedata[STEP_W-1:0];
    end

    // Latch the host access; hreq lasts one cycle unless renewed back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hreq  <= 1'b0;
            hwe   <= 1'b0;
            haddr <= '0;
            hdata <= '0;
        end else begin
            hreq <= host_acc;
            if (host_acc) begin
                hwe   <= cmd_acc;
                haddr <= address;
                if (cmd_acc) begin
                    hdata <= writedata[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/nes_mem_arbiter.sv
// Shares the 6502 program memory with the host. Host accesses steal one
// memory cycle by dropping cpu_ready; the CPU read data displaced by the
// steal is replayed on cpu_d_in in the cycle after the last steal.
//
// state    | meaning
// HALTED   | CPU stalled, only host accesses reach memory
// RUNNING  | CPU free-running except during steal cycles
// STEPPING | CPU runs for step_cnt ready cycles, then HALTED
module nes_mem_arbiter
    import nes_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [15:0]       writedata,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_d_out,
    output logic [DATA_W-1:0] cpu_d_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic [1:0]        run_state
);

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    logic              hreq;
    logic              hwe;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hdata;
    logic              host_acc;
    logic              cmd_halt;
    logic              cmd_start;
    logic              cmd_step;
    logic [STEP_W-1:0] step_val;

    run_state_t        state;
    run_state_t        state_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_nxt;

    logic              hreq_q;
    logic              replay;
    logic [DATA_W-1:0] hold;
    logic              rd_pend;

    nes_host_cmd_decode #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STEP_W(STEP_W)
    ) u_decode (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .address   (address),
        .hreq      (hreq),
        .hwe       (hwe),
        .haddr     (haddr),
        .hdata     (hdata),
        .host_acc  (host_acc),
        .cmd_halt  (cmd_halt),
        .cmd_start (cmd_start),
        .cmd_step  (cmd_step),
        .step_val  (step_val)
    );

    assign cpu_ready = ((state == RUNNING) || (state == STEPPING)) && !hreq;
    assign run_state = state;
    assign cpu_d_in  = replay ? hold : mem_out;

    // Memory grant: a pending host access always owns the port.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_write = cpu_write & cpu_ready;
        mem_in    = cpu_d_out;
        if (hreq) begin
            mem_addr  = haddr;
            mem_write = hwe;
            mem_in    = hdata;
        end
    end

    // Run-state register and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HALTED;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_nxt;
        end
    end

    // Next state: HALT wins, then START, then STEP (only from HALTED with a
    // nonzero count); stepping counts only cycles the CPU actually ran.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        if (cmd_halt) begin
            state_nxt = HALTED;
            step_nxt  = '0;
        end else if (cmd_start) begin
            state_nxt = RUNNING;
            step_nxt  = '0;
        end else if (cmd_step && (state == HALTED) && (step_val != '0)) begin
            state_nxt = STEPPING;
            step_nxt  = step_val;
        end else if ((state == STEPPING) && cpu_ready) begin
            step_nxt = step_cnt - STEP_ONE;
            if (step_cnt == STEP_ONE) begin
                state_nxt = HALTED;
            end
        end
    end

    // Replay capture and host read-return pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hreq_q        <= 1'b0;
            replay        <= 1'b0;
            hold          <= '0;
            rd_pend       <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            hreq_q <= hreq;
            // mem_out in the first steal cycle is the CPU's displaced read
            if (hreq && !hreq_q) begin
                hold <= mem_out;
            end
            replay        <= hreq & ~host_acc;
            rd_pend       <= hreq & ~hwe;
            readdatavalid <= rd_pend;
            if (rd_pend) begin
                readdata <= mem_out;
            end
        end
    end

endmodule
